// File: rtl/stage_writeback_vec_if.sv
// rtl/stage_writeback_vec_if.sv - memory-stage intake and register-file write port bundle
interface stage_writeback_vec_if #(
   parameter int XLEN       = 32,
   parameter int LANES      = 4,
   parameter int REG_ADDR_W = 5
);
   logic                    m_valid;
   logic                    m_ready;
   logic [1:0]              m_result_src;
   logic                    m_reg_write;
   logic [REG_ADDR_W-1:0]   m_rd;
   logic [LANES-1:0]        m_lane_mask;
   logic [1:0]              m_ld_size;
   logic                    m_ld_unsigned;
   logic [LANES*XLEN-1:0]   m_alu_result;
   logic [LANES*XLEN-1:0]   m_read_result;
   logic [XLEN-1:0]         m_pc_plus_4;
   logic [XLEN-1:0]         m_imm_ext;
   logic                    wb_valid;
   logic                    rf_ready;
   logic [REG_ADDR_W-1:0]   wb_rd;
   logic [LANES-1:0]        wb_we;
   logic [LANES*XLEN-1:0]   wb_result;
   logic                    fwd_valid;
   logic [63:0]             instret;

   // Upstream stage plus register file: offers instructions, accepts writes
   modport master (
      output m_valid, m_result_src, m_reg_write, m_rd, m_lane_mask, m_ld_size,
             m_ld_unsigned, m_alu_result, m_read_result, m_pc_plus_4, m_imm_ext,
             rf_ready,
      input  m_ready, wb_valid, wb_rd, wb_we, wb_result, fwd_valid, instret
   );

   // Writeback stage itself
   modport slave (
      input  m_valid, m_result_src, m_reg_write, m_rd, m_lane_mask, m_ld_size,
             m_ld_unsigned, m_alu_result, m_read_result, m_pc_plus_4, m_imm_ext,
             rf_ready,
      output m_ready, wb_valid, wb_rd, wb_we, wb_result, fwd_valid, instret
   );
endinterface

// File: rtl/stage_writeback_vec.sv
// rtl/stage_writeback_vec.sv - buffered multi-lane writeback stage with result select and load extension
module stage_writeback_vec #(
   parameter int XLEN       = 32,
   parameter int LANES      = 4,
   parameter int REG_ADDR_W = 5,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   stage_writeback_vec_if.slave  bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // Raw per-entry fields; selection and extension are done on the head only
   logic [1:0]              q_src   [DEPTH];
   logic                    q_rw    [DEPTH];
   logic [REG_ADDR_W-1:0]   q_rd    [DEPTH];
   logic [LANES-1:0]        q_mask  [DEPTH];
   logic [1:0]              q_size  [DEPTH];
   logic                    q_uns   [DEPTH];
   logic [LANES*XLEN-1:0]   q_alu   [DEPTH];
   logic [LANES*XLEN-1:0]   q_load  [DEPTH];
   logic [XLEN-1:0]         q_pc4   [DEPTH];
   logic [XLEN-1:0]         q_imm   [DEPTH];

   logic [PW-1:0]           wr_ptr;
   logic [PW-1:0]           rd_ptr;
   logic [CW-1:0]           count;
   logic [63:0]             instret_r;

   logic                    push;
   logic                    pop;
   logic                    head_valid;

   logic [1:0]              head_src;
   logic                    head_rw;
   logic [REG_ADDR_W-1:0]   head_rd;
   logic [LANES-1:0]        head_mask;
   logic [1:0]              head_size;
   logic                    head_uns;
   logic [LANES*XLEN-1:0]   head_alu;
   logic [LANES*XLEN-1:0]   head_load;
   logic [XLEN-1:0]         head_pc4;
   logic [XLEN-1:0]         head_imm;

   logic [LANES*XLEN-1:0]   result_c;
   logic [XLEN-1:0]         lane_raw;
   logic [XLEN-1:0]         lane_ext;
   logic                    lane_fill;
   int                      lane_bits;

   // A full FIFO refuses pushes even when the head pops in the same cycle
   assign bus.m_ready = (count < DEPTH_C) & rst_n;
   assign push        = bus.m_valid & bus.m_ready;
   assign head_valid  = (count != '0);
   assign pop         = head_valid & bus.rf_ready;

   assign head_src  = q_src[rd_ptr];
   assign head_rw   = q_rw[rd_ptr];
   assign head_rd   = q_rd[rd_ptr];
   assign head_mask = q_mask[rd_ptr];
   assign head_size = q_size[rd_ptr];
   assign head_uns  = q_uns[rd_ptr];
   assign head_alu  = q_alu[rd_ptr];
   assign head_load = q_load[rd_ptr];
   assign head_pc4  = q_pc4[rd_ptr];
   assign head_imm  = q_imm[rd_ptr];

   // Payload storage: written on push, no reset needed since count gates visibility
   always_ff @(posedge clk) begin
      if (push) begin
         q_src[wr_ptr]  <= bus.m_result_src;
         q_rw[wr_ptr]   <= bus.m_reg_write;
         q_rd[wr_ptr]   <= bus.m_rd;
         q_mask[wr_ptr] <= bus.m_lane_mask;
         q_size[wr_ptr] <= bus.m_ld_size;
         q_uns[wr_ptr]  <= bus.m_ld_unsigned;
         q_alu[wr_ptr]  <= bus.m_alu_result;
         q_load[wr_ptr] <= bus.m_read_result;
         q_pc4[wr_ptr]  <= bus.m_pc_plus_4;
         q_imm[wr_ptr]  <= bus.m_imm_ext;
      end
   end

   // FIFO occupancy, pointers and retire counter; reset drops in-flight entries
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         instret_r <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (!push && pop) count <= count - CW'(1);
         if (pop) instret_r <= instret_r + 64'd1;
      end
   end

   // Per-lane result select; loads are narrowed to 8/16/32 bits then sign/zero filled
   always_comb begin
      result_c  = '0;
      lane_raw  = '0;
      lane_ext  = '0;
      lane_fill = 1'b0;
      lane_bits = 32;
      for (int i = 0; i < LANES; i++) begin
         lane_raw = head_load[i*XLEN +: XLEN];
         case (head_size)
            2'b00:   begin lane_bits = 8;  lane_fill = ~head_uns & lane_raw[7];  end
            2'b01:   begin lane_bits = 16; lane_fill = ~head_uns & lane_raw[15]; end
            default: begin lane_bits = 32; lane_fill = ~head_uns & lane_raw[31]; end
         endcase
         for (int b = 0; b < XLEN; b++) begin
            lane_ext[b] = (b < lane_bits) ? lane_raw[b] : lane_fill;
         end
         case (head_src)
            2'b00:   result_c[i*XLEN +: XLEN] = head_alu[i*XLEN +: XLEN];
            2'b01:   result_c[i*XLEN +: XLEN] = lane_ext;
            2'b10:   result_c[i*XLEN +: XLEN] = head_pc4;
            default: result_c[i*XLEN +: XLEN] = head_imm;
         endcase
      end
   end

   assign bus.wb_valid  = head_valid;
   assign bus.wb_rd     = head_rd;
   assign bus.wb_result = result_c;
   assign bus.wb_we     = {LANES{head_valid & head_rw & (head_rd != '0)}} & head_mask;
   assign bus.fwd_valid = head_valid & (|bus.wb_we);
   assign bus.instret   = instret_r;
endmodule

// File: tb/tb_stage_writeback_vec.sv
// tb/tb_stage_writeback_vec.sv - table-driven scoreboard bench for stage_writeback_vec
module tb_stage_writeback_vec;
   logic clk = 1'b0;
   logic rst_n;
   int   n_vec = 0;
   int   n_miss = 0;

   always #5 clk = ~clk;

   stage_writeback_vec_if #(.XLEN(32), .LANES(4), .REG_ADDR_W(5)) bus ();

   stage_writeback_vec #(.XLEN(32), .LANES(4), .REG_ADDR_W(5), .DEPTH(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [1:0]   src;
      logic         rw;
      logic [4:0]   rd;
      logic [3:0]   mask;
      logic [1:0]   size;
      logic         uns;
      logic [127:0] alu;
      logic [127:0] rdat;
      logic [31:0]  pc4;
      logic [31:0]  imm;
      logic [3:0]   exp_we;
      logic [127:0] exp_res;
   } vec_t;

   typedef struct {
      logic [4:0]   rd;
      logic [3:0]   we;
      logic [127:0] res;
   } exp_t;

   vec_t tbl [12];
   exp_t exp_q [$];

   function automatic vec_t mk(input logic [1:0] src, input logic rw, input logic [4:0] rd,
                               input logic [3:0] mask, input logic [1:0] size, input logic uns,
                               input logic [127:0] alu, input logic [127:0] rdat,
                               input logic [31:0] pc4, input logic [31:0] imm,
                               input logic [3:0] we, input logic [127:0] res);
      vec_t v;
      v.src = src; v.rw = rw; v.rd = rd; v.mask = mask; v.size = size; v.uns = uns;
      v.alu = alu; v.rdat = rdat; v.pc4 = pc4; v.imm = imm; v.exp_we = we; v.exp_res = res;
      return v;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send(input vec_t v, output int waited);
      exp_t e;
      bus.m_valid       = 1'b1;
      bus.m_result_src  = v.src;
      bus.m_reg_write   = v.rw;
      bus.m_rd          = v.rd;
      bus.m_lane_mask   = v.mask;
      bus.m_ld_size     = v.size;
      bus.m_ld_unsigned = v.uns;
      bus.m_alu_result  = v.alu;
      bus.m_read_result = v.rdat;
      bus.m_pc_plus_4   = v.pc4;
      bus.m_imm_ext     = v.imm;
      waited = 0;
      forever begin
         @(negedge clk);
         if (bus.m_ready) break;
         waited++;
         if (waited > 40) break;
         @(posedge clk); #1;
      end
      if (waited > 40) begin
         check("send_timeout", 128'(waited), 128'd0);
      end else begin
         e.rd = v.rd; e.we = v.exp_we; e.res = v.exp_res;
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      bus.m_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      if (exp_q.size() != 0) check("drain_timeout", 128'(exp_q.size()), 128'd0);
   endtask

   // Scoreboard: compare the presented head every cycle, retire it when the RF accepts
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.wb_valid) begin
         if (exp_q.size() == 0) begin
            check("wb_unexpected", 128'(bus.wb_valid), 128'd0);
         end else begin
            e = exp_q[0];
            check("wb_rd", 128'(bus.wb_rd), 128'(e.rd));
            check("wb_we", 128'(bus.wb_we), 128'(e.we));
            check("wb_result", bus.wb_result, e.res);
            check("fwd_valid", 128'(bus.fwd_valid), 128'(e.we != 4'd0));
            if (bus.rf_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      tbl[0]  = mk(2'b00, 1'b1, 5'd5, 4'hF, 2'b10, 1'b0,
                   {32'd4, 32'd3, 32'd2, 32'd1}, '0, 32'h100, 32'h0,
                   4'hF, {32'd4, 32'd3, 32'd2, 32'd1});
      tbl[1]  = mk(2'b01, 1'b1, 5'd6, 4'hF, 2'b00, 1'b0, {4{32'hAAAA_AAAA}},
                   {32'h1234_5600, 32'h0000_01FF, 32'h0000_007F, 32'h0000_0080}, 32'h200, 32'h55,
                   4'hF, {32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_007F, 32'hFFFF_FF80});
      tbl[2]  = mk(2'b01, 1'b1, 5'd7, 4'hF, 2'b01, 1'b1, {4{32'hAAAA_AAAA}},
                   {32'hABCD_7FFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_8001}, 32'h200, 32'h55,
                   4'hF, {32'h0000_7FFF, 32'h0000_0000, 32'h0000_FFFF, 32'h0000_8001});
      tbl[3]  = mk(2'b01, 1'b1, 5'd8, 4'hF, 2'b01, 1'b0, {4{32'hAAAA_AAAA}},
                   {32'h1234_F000, 32'hFFFF_0000, 32'h0000_7FFF, 32'h0000_8001}, 32'h200, 32'h55,
                   4'hF, {32'hFFFF_F000, 32'h0000_0000, 32'h0000_7FFF, 32'hFFFF_8001});
      tbl[4]  = mk(2'b01, 1'b1, 5'd9, 4'hF, 2'b10, 1'b0, {4{32'hAAAA_AAAA}},
                   {32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'hDEAD_BEEF}, 32'h200, 32'h55,
                   4'hF, {32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'hDEAD_BEEF});
      tbl[5]  = mk(2'b01, 1'b1, 5'd10, 4'hF, 2'b11, 1'b1, {4{32'hAAAA_AAAA}},
                   {32'hCAFE_F00D, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0080}, 32'h200, 32'h55,
                   4'hF, {32'hCAFE_F00D, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0080});
      tbl[6]  = mk(2'b01, 1'b1, 5'd11, 4'hF, 2'b00, 1'b1, {4{32'hAAAA_AAAA}},
                   {32'h0000_00FF, 32'h0000_0180, 32'hFFFF_FF7F, 32'h0000_0000}, 32'h200, 32'h55,
                   4'hF, {32'h0000_00FF, 32'h0000_0080, 32'h0000_007F, 32'h0000_0000});
      tbl[7]  = mk(2'b10, 1'b1, 5'd31, 4'h5, 2'b00, 1'b0, {4{32'h1111_1111}}, {4{32'h2222_2222}},
                   32'h0000_1004, 32'h77, 4'h5, {4{32'h0000_1004}});
      tbl[8]  = mk(2'b11, 1'b1, 5'd1, 4'h8, 2'b00, 1'b0, {4{32'h1111_1111}}, {4{32'h2222_2222}},
                   32'h0000_1004, 32'hFFFF_F800, 4'h8, {4{32'hFFFF_F800}});
      tbl[9]  = mk(2'b00, 1'b1, 5'd0, 4'hF, 2'b10, 1'b0,
                   {32'h40, 32'h30, 32'h20, 32'h10}, '0, 32'h0, 32'h0,
                   4'h0, {32'h40, 32'h30, 32'h20, 32'h10});
      tbl[10] = mk(2'b01, 1'b0, 5'd7, 4'hF, 2'b00, 1'b0, {4{32'h1111_1111}}, {4{32'h0000_0080}},
                   32'h0, 32'h0, 4'h0, {4{32'hFFFF_FF80}});
      tbl[11] = mk(2'b00, 1'b1, 5'd9, 4'h6, 2'b10, 1'b0,
                   {32'h9, 32'h8, 32'h7, 32'h6}, '0, 32'h0, 32'h0,
                   4'h6, {32'h9, 32'h8, 32'h7, 32'h6});

      // Reset state
      rst_n = 1'b0;
      bus.rf_ready = 1'b1;
      bus.m_valid = 1'b0;
      bus.m_result_src = '0; bus.m_reg_write = 1'b0; bus.m_rd = '0; bus.m_lane_mask = '0;
      bus.m_ld_size = '0; bus.m_ld_unsigned = 1'b0; bus.m_alu_result = '0;
      bus.m_read_result = '0; bus.m_pc_plus_4 = '0; bus.m_imm_ext = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_wb_valid", 128'(bus.wb_valid), 128'd0);
      check("rst_m_ready", 128'(bus.m_ready), 128'd0);
      check("rst_wb_we", 128'(bus.wb_we), 128'd0);
      check("rst_fwd", 128'(bus.fwd_valid), 128'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_m_ready", 128'(bus.m_ready), 128'd1);
      check("rel_instret", 128'(bus.instret), 128'd0);
      @(posedge clk); #1;

      // Single ALU op: visible the cycle after acceptance, then retired
      send(tbl[0], w);
      @(negedge clk);
      check("t1_latency_valid", 128'(bus.wb_valid), 128'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("t1_instret", 128'(bus.instret), 128'd1);
      @(posedge clk); #1;

      // Table vectors back to back with the register file always ready
      for (int i = 0; i < 12; i++) send(tbl[i], w);
      wait_drain();
      @(negedge clk);
      check("tbl_instret", 128'(bus.instret), 128'd13);
      @(posedge clk); #1;

      // Backpressure: two accepts fill the FIFO, third waits until the RF drains
      bus.rf_ready = 1'b0;
      send(tbl[0], w);
      send(tbl[7], w);
      @(negedge clk);
      check("bp_full_ready", 128'(bus.m_ready), 128'd0);
      @(posedge clk); #1;
      fork
         send(tbl[8], w);
         begin
            repeat (3) begin
               @(negedge clk);
               check("bp_hold_ready", 128'(bus.m_ready), 128'd0);
            end
            @(posedge clk); #1;
            bus.rf_ready = 1'b1;
         end
      join
      check("bp_third_waited", 128'(w > 0), 128'd1);
      wait_drain();
      @(negedge clk);
      check("bp_instret", 128'(bus.instret), 128'd16);
      @(posedge clk); #1;

      // Simultaneous push and pop at count 1: no stall on any of ten pushes
      send(tbl[1], w);
      for (int k = 0; k < 10; k++) begin
         send(tbl[(k + 2) % 12], w);
         check("sim_no_stall", 128'(w), 128'd0);
      end
      wait_drain();
      @(negedge clk);
      check("sim_instret", 128'(bus.instret), 128'd27);
      @(posedge clk); #1;

      // Reset while two entries are held
      bus.rf_ready = 1'b0;
      send(tbl[2], w);
      send(tbl[3], w);
      rst_n = 1'b0;
      @(posedge clk);
      exp_q.delete();
      #1;
      @(negedge clk);
      check("mid_rst_wb_valid", 128'(bus.wb_valid), 128'd0);
      check("mid_rst_instret", 128'(bus.instret), 128'd0);
      check("mid_rst_m_ready", 128'(bus.m_ready), 128'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.rf_ready = 1'b1;
      @(negedge clk);
      check("post_rst_m_ready", 128'(bus.m_ready), 128'd1);
      check("post_rst_empty", 128'(bus.wb_valid), 128'd0);
      @(posedge clk); #1;
      send(tbl[4], w);
      wait_drain();
      @(negedge clk);
      check("post_rst_instret", 128'(bus.instret), 128'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
